// File: rtl/dispram_rd_if.sv
// Bundle of the frame-RAM port B read path: scanout requester, aux requester
// and the RAM-side address/data pins.
interface dispram_rd_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 12
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_valid;
  logic [DATA_W-1:0] disp_data;
  logic              aux_req;
  logic [ADDR_W-1:0] aux_addr;
  logic              aux_gnt;
  logic              aux_valid;
  logic [DATA_W-1:0] aux_data;
  logic              aux_err;
  logic              aux_starved;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dout;

  modport slave (
    input  disp_req, disp_addr, aux_req, aux_addr, ram_dout,
    output disp_valid, disp_data, aux_gnt, aux_valid, aux_data, aux_err,
           aux_starved, ram_addr
  );

  modport master (
    output disp_req, disp_addr, aux_req, aux_addr, ram_dout,
    input  disp_valid, disp_data, aux_gnt, aux_valid, aux_data, aux_err,
           aux_starved, ram_addr
  );
endinterface

// File: rtl/dispram_rd_arbiter.sv
// Fixed-priority arbiter for frame-RAM port B: scanout always wins, aux reads
// fill idle cycles; a tag pipeline steers returning data to its requester.
module dispram_rd_arbiter #(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 12,
  parameter int DEPTH        = 307200,
  parameter int RD_LAT       = 2,
  parameter int STARVE_LIMIT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  dispram_rd_if.slave bus
);
  typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_AUX, TAG_ERR} tag_e;

  localparam int                 CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_W:0]    DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0]   CNT_HIT = CNT_W'(STARVE_LIMIT - 1);

  logic              w_gnt, w_ld, w_wait;
  logic [ADDR_W-1:0] w_addr;
  tag_e              w_tag, w_out_tag;

  logic [ADDR_W-1:0]      r_ram_addr;
  logic [RD_LAT:0][1:0]   r_tag_pipe;
  logic                   r_disp_valid, r_aux_valid, r_aux_err;
  logic [DATA_W-1:0]      r_disp_data, r_aux_data;
  logic [CNT_W-1:0]       r_cnt;

  always_comb begin
    w_gnt  = 1'b0;
    w_ld   = 1'b0;
    w_tag  = TAG_NONE;
    w_addr = bus.disp_addr;
    if (bus.disp_req) begin
      w_ld  = 1'b1;
      w_tag = TAG_DISP;
    end else if (bus.aux_req) begin
      w_gnt  = 1'b1;
      w_addr = bus.aux_addr;
      // Out-of-range aux reads never touch the RAM; the error rides the tag pipe.
      if ({1'b0, bus.aux_addr} < DEPTH_L) begin
        w_ld  = 1'b1;
        w_tag = TAG_AUX;
      end else begin
        w_tag = TAG_ERR;
      end
    end
    if (!i_rst_n) w_gnt = 1'b0;
  end

  assign w_wait    = i_rst_n & bus.aux_req & ~w_gnt;
  assign w_out_tag = tag_e'(r_tag_pipe[RD_LAT]);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ram_addr   <= '0;
      r_tag_pipe   <= '0;
      r_disp_valid <= 1'b0;
      r_aux_valid  <= 1'b0;
      r_aux_err    <= 1'b0;
      r_disp_data  <= '0;
      r_aux_data   <= '0;
      r_cnt        <= '0;
    end else begin
      if (w_ld) r_ram_addr <= w_addr;
      r_tag_pipe[0] <= w_tag;
      for (int i = 1; i <= RD_LAT; i++) r_tag_pipe[i] <= r_tag_pipe[i-1];

      r_disp_valid <= (w_out_tag == TAG_DISP);
      r_aux_valid  <= (w_out_tag == TAG_AUX) || (w_out_tag == TAG_ERR);
      r_aux_err    <= (w_out_tag == TAG_ERR);
      if (w_out_tag == TAG_DISP) r_disp_data <= bus.ram_dout;
      if (w_out_tag == TAG_AUX)  r_aux_data  <= bus.ram_dout;
      if (w_out_tag == TAG_ERR)  r_aux_data  <= '0;

      if (!w_wait)              r_cnt <= '0;
      else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.aux_gnt     = w_gnt;
  assign bus.aux_starved = w_wait && (r_cnt == CNT_HIT);
  assign bus.ram_addr    = r_ram_addr;
  assign bus.disp_valid  = r_disp_valid;
  assign bus.disp_data   = r_disp_data;
  assign bus.aux_valid   = r_aux_valid;
  assign bus.aux_data    = r_aux_data;
  assign bus.aux_err     = r_aux_err;
endmodule

// File: tb/tb_dispram_rd_arbiter.sv
// Directed bench for dispram_rd_arbiter with a 2-cycle-latency RAM model.
module tb_dispram_rd_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  dispram_rd_if #(.ADDR_W(19), .DATA_W(12)) bus();

  dispram_rd_arbiter dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  // RAM returns ram_addr[11:0] two cycles after the address is presented
  logic [11:0] rp0 = '0;
  logic [11:0] rp1 = '0;
  always @(posedge clk) begin
    rp0 <= bus.ram_addr[11:0];
    rp1 <= rp0;
  end
  assign bus.ram_dout = rp1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs just after the edge, then sample at the falling edge.
  task automatic step(input logic dr, input logic [18:0] da, input logic ar, input logic [18:0] aa);
    @(posedge clk); #1;
    bus.disp_req  = dr;
    bus.disp_addr = da;
    bus.aux_req   = ar;
    bus.aux_addr  = aa;
    @(negedge clk);
    chk("excl", 32'(bus.disp_valid & bus.aux_valid), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dv"}, 32'(bus.disp_valid), 0);
    chk({tag, "_dd"}, 32'(bus.disp_data), 0);
    chk({tag, "_av"}, 32'(bus.aux_valid), 0);
    chk({tag, "_ad"}, 32'(bus.aux_data), 0);
    chk({tag, "_ae"}, 32'(bus.aux_err), 0);
    chk({tag, "_st"}, 32'(bus.aux_starved), 0);
    chk({tag, "_ra"}, 32'(bus.ram_addr), 0);
    chk({tag, "_gnt"}, 32'(bus.aux_gnt), 0);
  endtask

  initial begin
    bus.disp_req = 1'b0; bus.disp_addr = '0; bus.aux_req = 1'b0; bus.aux_addr = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1 chk_all_zero("rst");
    rst_n = 1'b1;

    // display-only burst, addresses 0..5
    for (int i = 0; i < 11; i++) begin
      step(i < 6, 19'(i), 1'b0, 19'd0);
      chk("burst_dv", 32'(bus.disp_valid), 32'(i >= 4 && i <= 9));
      if (i >= 4 && i <= 9) chk("burst_dd", 32'(bus.disp_data), 32'(i - 4));
      chk("burst_av", 32'(bus.aux_valid), 0);
    end

    // aux read in an idle cycle
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 19'd0, i == 0, 19'd100);
      chk("idle_gnt", 32'(bus.aux_gnt), 32'(i == 0));
      chk("idle_av", 32'(bus.aux_valid), 32'(i == 4));
      if (i == 4) begin
        chk("idle_ad", 32'(bus.aux_data), 32'd100);
        chk("idle_ae", 32'(bus.aux_err), 0);
      end
    end

    // contention: display 200..204, aux addr 7 waits until display stops
    for (int k = 0; k < 11; k++) begin
      step(k < 5, 19'(200 + k), k >= 1 && k <= 5, 19'd7);
      chk("cont_gnt", 32'(bus.aux_gnt), 32'(k == 5));
      chk("cont_dv", 32'(bus.disp_valid), 32'(k >= 4 && k <= 8));
      if (k >= 4 && k <= 8) chk("cont_dd", 32'(bus.disp_data), 32'(200 + k - 4));
      chk("cont_av", 32'(bus.aux_valid), 32'(k == 9));
      if (k == 9) chk("cont_ad", 32'(bus.aux_data), 32'd7);
    end

    // out-of-range aux address: granted, RAM address untouched, error response
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 19'd0, i == 0, 19'd307200);
      chk("oor_gnt", 32'(bus.aux_gnt), 32'(i == 0));
      if (i == 1) chk("oor_ra", 32'(bus.ram_addr), 32'd7);
      chk("oor_av", 32'(bus.aux_valid), 32'(i == 4));
      if (i == 4) begin
        chk("oor_ae", 32'(bus.aux_err), 32'd1);
        chk("oor_ad", 32'(bus.aux_data), 32'd0);
      end
    end

    // last valid address is accepted normally
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 19'd0, i == 0, 19'd307199);
      if (i == 1) chk("last_ra", 32'(bus.ram_addr), 32'd307199);
      chk("last_av", 32'(bus.aux_valid), 32'(i == 4));
      if (i == 4) begin
        chk("last_ae", 32'(bus.aux_err), 32'd0);
        chk("last_ad", 32'(bus.aux_data), 32'hFFF);
      end
    end

    // starvation: display held 25 cycles while aux waits
    for (int k = 0; k < 31; k++) begin
      step(k < 25, 19'(k), k <= 25, 19'd50);
      chk("stv_pulse", 32'(bus.aux_starved), 32'(k == 15));
      chk("stv_gnt", 32'(bus.aux_gnt), 32'(k == 25));
      chk("stv_av", 32'(bus.aux_valid), 32'(k == 29));
      if (k == 29) chk("stv_ad", 32'(bus.aux_data), 32'd50);
    end

    // reset with reads in flight
    step(1'b1, 19'd5, 1'b0, 19'd0);
    step(1'b0, 19'd0, 1'b1, 19'd9);
    chk("mid_gnt", 32'(bus.aux_gnt), 32'd1);
    @(posedge clk); #1;
    bus.disp_req = 1'b0;
    bus.aux_req  = 1'b1;
    rst_n = 1'b0;
    #1 chk_all_zero("mid_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.aux_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 19'd0, 1'b0, 19'd0);
      chk("post_dv", 32'(bus.disp_valid), 0);
      chk("post_av", 32'(bus.aux_valid), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
